// File: rtl/cache_ctrl_nway_pkg.sv
// cache_pkg: shared types and width helpers for the N-way cache controller.
//   state_e            controller FSM state
//   off_w/idx_w/tag_w  byte-address field widths derived from the geometry
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      REFILL    = 2'd3
   } state_e;

   function automatic int unsigned off_w(input int unsigned words);
      return $clog2(words) + 2;
   endfunction

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned sets,
                                         input int unsigned words);
      return addr_w - idx_w(sets) - off_w(words);
   endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// cache_ctrl_nway_if: CPU request, data-array and line-burst memory signals
// of the N-way cache controller.
//   master : controller side (takes CPU requests and mem_ack, drives the rest)
//   slave  : environment side (CPU, data array, memory)
interface cache_ctrl_nway_if #(
   parameter int unsigned WAYS   = 4,
   parameter int unsigned SETS   = 8,
   parameter int unsigned WORDS  = 8,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned IDX_W = cache_pkg::idx_w(SETS);
   localparam int unsigned WRD_W = $clog2(WORDS);

   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic              busy;
   logic              rd_done;
   logic              wr_done;
   logic [WAY_W-1:0]  da_way;
   logic [IDX_W-1:0]  da_set;
   logic [WRD_W-1:0]  da_word;
   logic              da_we;
   logic              da_src_mem;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;

   modport master (
      input  cpu_rd, cpu_wr, cpu_addr, mem_ack,
      output busy, rd_done, wr_done, da_way, da_set, da_word, da_we,
             da_src_mem, mem_req, mem_we, mem_addr
   );

   modport slave (
      output cpu_rd, cpu_wr, cpu_addr, mem_ack,
      input  busy, rd_done, wr_done, da_way, da_set, da_word, da_we,
             da_src_mem, mem_req, mem_we, mem_addr
   );

endinterface

// File: rtl/cache_lru_ages.sv
// cache_lru_ages: per-set LRU age storage for the N-way cache.
//   CLK, reset : clock, synchronous active-high reset (ages = way index)
//   upd_i      : access to way_i in set_i this cycle
//   set_i      : set being accessed / looked up
//   way_i      : accessed way
//   victim_o   : way in set_i whose age is WAYS-1
module cache_lru_ages #(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 8
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    upd_i,
   input  logic [$clog2(SETS)-1:0] set_i,
   input  logic [$clog2(WAYS)-1:0] way_i,
   output logic [$clog2(WAYS)-1:0] victim_o
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   logic [WAY_W-1:0] age_q [SETS][WAYS];

   // Accessed way becomes youngest; only ways younger than it age by one,
   // so each set stays a permutation of 0..WAYS-1.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
               age_q[s][w] <= WAY_W'(w);
      end else if (upd_i) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way_i)
               age_q[set_i][w] <= '0;
            else if (age_q[set_i][w] < age_q[set_i][way_i])
               age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
         end
      end
   end

   always_comb begin
      victim_o = '0;
      for (int unsigned w = 0; w < WAYS; w++)
         if (age_q[set_i][w] == WAY_W'(WAYS - 1))
            victim_o = WAY_W'(w);
   end

endmodule

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative, write-back, write-allocate cache
// controller. Holds tag/valid/dirty/LRU state, drives the external data
// array and a word-beat memory interface.
//   CLK, reset : clock, synchronous active-high reset
//   bus        : cache_ctrl_nway_if.master (CPU request, data array, memory)
//   hit_cnt_o/miss_cnt_o equivalents hit_cnt, miss_cnt : saturating counters,
//                present only when CACHE_STATS_EN is defined
module cache_ctrl_nway
   import cache_pkg::*;
#(
   parameter int unsigned WAYS   = 4,
   parameter int unsigned SETS   = 8,
   parameter int unsigned WORDS  = 8,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              reset,
   cache_ctrl_nway_if.master bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);
   localparam int unsigned OFF_W = off_w(WORDS);
   localparam int unsigned IDX_W = idx_w(SETS);
   localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, WORDS);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned WRD_W = $clog2(WORDS);
   localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [TAG_W-1:0] req_tag_q, req_tag_d;
   logic [IDX_W-1:0] req_set_q, req_set_d;
   logic [WRD_W-1:0] req_word_q, req_word_d;
   logic             req_wr_q, req_wr_d;
   logic [WRD_W-1:0] beat_q, beat_d;
   logic [WAY_W-1:0] victim_q, victim_d;

   logic [TAG_W-1:0]            tag_q [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0]   valid_q;
   logic [SETS-1:0][WAYS-1:0]   dirty_q;

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             inv_found;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] lru_victim;
   logic [WAY_W-1:0] victim;
   logic             accept, lru_upd, set_dirty, wb_done, fill_done;

   logic              rd_done, wr_done, da_we, da_src_mem, mem_req, mem_we;
   logic [WAY_W-1:0]  da_way;
   logic [IDX_W-1:0]  da_set;
   logic [WRD_W-1:0]  da_word;
   logic [ADDR_W-1:0] mem_addr;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.cpu_addr[1:0];

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[req_set_q][w] && tag_q[req_set_q][w] == req_tag_q) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!inv_found && !valid_q[req_set_q][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : lru_victim;
   end

   cache_lru_ages #(.WAYS(WAYS), .SETS(SETS)) u_lru (
      .CLK      (CLK),
      .reset    (reset),
      .upd_i    (lru_upd),
      .set_i    (req_set_q),
      .way_i    (hit_way),
      .victim_o (lru_victim)
   );

   always_comb begin
      state_d    = state_q;
      req_tag_d  = req_tag_q;
      req_set_d  = req_set_q;
      req_word_d = req_word_q;
      req_wr_d   = req_wr_q;
      beat_d     = beat_q;
      victim_d   = victim_q;
      accept     = 1'b0;
      lru_upd    = 1'b0;
      set_dirty  = 1'b0;
      wb_done    = 1'b0;
      fill_done  = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      da_we      = 1'b0;
      da_src_mem = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      da_way     = '0;
      da_set     = '0;
      da_word    = '0;
      mem_addr   = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.cpu_rd || bus.cpu_wr) begin
               accept     = 1'b1;
               req_tag_d  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
               req_set_d  = bus.cpu_addr[OFF_W +: IDX_W];
               req_word_d = bus.cpu_addr[2 +: WRD_W];
               req_wr_d   = bus.cpu_wr;
               state_d    = COMPARE;
            end
         end
         COMPARE: begin
            da_set = req_set_q;
            if (hit) begin
               da_way    = hit_way;
               da_word   = req_word_q;
               rd_done   = !req_wr_q;
               wr_done   = req_wr_q;
               da_we     = req_wr_q;
               set_dirty = req_wr_q;
               lru_upd   = 1'b1;
               state_d   = IDLE;
            end else begin
               victim_d = victim;
               beat_d   = '0;
               state_d  = dirty_q[req_set_q][victim] ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tag_q[req_set_q][victim_q], req_set_q, beat_q, 2'b00};
            da_way   = victim_q;
            da_set   = req_set_q;
            da_word  = beat_q;
            if (bus.mem_ack) begin
               // counter wraps to 0 after the last beat, ready for refill
               beat_d = beat_q + WRD_W'(1);
               if (beat_q == LAST_BEAT) begin
                  wb_done = 1'b1;
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            mem_req    = 1'b1;
            mem_addr   = {req_tag_q, req_set_q, beat_q, 2'b00};
            da_way     = victim_q;
            da_set     = req_set_q;
            da_word    = beat_q;
            da_src_mem = 1'b1;
            if (bus.mem_ack) begin
               da_we  = 1'b1;
               beat_d = beat_q + WRD_W'(1);
               if (beat_q == LAST_BEAT) begin
                  fill_done = 1'b1;
                  state_d   = COMPARE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         req_tag_q  <= '0;
         req_set_q  <= '0;
         req_word_q <= '0;
         req_wr_q   <= 1'b0;
         beat_q     <= '0;
         victim_q   <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_tag_q  <= req_tag_d;
         req_set_q  <= req_set_d;
         req_word_q <= req_word_d;
         req_wr_q   <= req_wr_d;
         beat_q     <= beat_d;
         victim_q   <= victim_d;
         if (set_dirty) dirty_q[req_set_q][hit_way] <= 1'b1;
         if (wb_done)   dirty_q[req_set_q][victim_q] <= 1'b0;
         if (fill_done) begin
            valid_q[req_set_q][victim_q] <= 1'b1;
            dirty_q[req_set_q][victim_q] <= 1'b0;
         end
      end
   end

   // Tags are qualified by valid bits, so they need no reset.
   always_ff @(posedge CLK) begin
      if (fill_done) tag_q[req_set_q][victim_q] <= req_tag_q;
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        first_q;

   // first_q distinguishes the CPU-initiated compare from the post-refill one.
   always_ff @(posedge CLK) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         first_q    <= 1'b0;
      end else begin
         if (accept)         first_q <= 1'b1;
         else if (fill_done) first_q <= 1'b0;
         if (state_q == COMPARE && hit && first_q && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == COMPARE && !hit && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

   assign bus.busy       = (state_q != IDLE);
   assign bus.rd_done    = rd_done;
   assign bus.wr_done    = wr_done;
   assign bus.da_way     = da_way;
   assign bus.da_set     = da_set;
   assign bus.da_word    = da_word;
   assign bus.da_we      = da_we;
   assign bus.da_src_mem = da_src_mem;
   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb_cache_ctrl_nway: randomized self-checking bench for cache_ctrl_nway.
// Reference model keeps per-set tag/valid/dirty arrays plus an explicit
// MRU-first recency list; expected beats and victims come from that model.
// Define CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_cache_ctrl_nway;
   localparam int unsigned WAYS   = 4;
   localparam int unsigned SETS   = 8;
   localparam int unsigned WORDS  = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned OFF_W  = 5;
   localparam int unsigned IDX_W  = 3;

   logic CLK   = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   cache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W)) bus ();

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   int unsigned m_tag   [SETS][WAYS];
   bit          m_valid [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   int unsigned m_order [SETS][WAYS];   // index 0 = most recently used way
   int unsigned m_hits, m_misses;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int unsigned s = 0; s < SETS; s++)
         for (int unsigned w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_order[s][w] = w;
         end
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic touch(input int unsigned s, input int unsigned w);
      int unsigned p = 0;
      for (int unsigned i = 0; i < WAYS; i++)
         if (m_order[s][i] == w) p = i;
      for (int unsigned i = p; i > 0; i--)
         m_order[s][i] = m_order[s][i-1];
      m_order[s][0] = w;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      check_eq("rst_busy",    bus.busy,     0);
      check_eq("rst_rd_done", bus.rd_done,  0);
      check_eq("rst_wr_done", bus.wr_done,  0);
      check_eq("rst_da_we",   bus.da_we,    0);
      check_eq("rst_mem_req", bus.mem_req,  0);
      check_eq("rst_mem_we",  bus.mem_we,   0);
      check_eq("rst_buses",   {bus.da_way, bus.da_set, bus.da_word, bus.da_src_mem}, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr);
      int unsigned tag, set, word, way, vic, nbeats, beats_exp, cyc, b;
      bit hit, is_wr, wb, in_wb, done;
      logic [31:0] exp_addr;
      is_wr = wr;
      tag  = addr >> (OFF_W + IDX_W);
      set  = (addr >> OFF_W) % SETS;
      word = (addr >> 2) % WORDS;
      hit = 1'b0;
      way = 0;
      for (int unsigned w = 0; w < WAYS; w++)
         if (!hit && m_valid[set][w] && m_tag[set][w] == tag) begin
            hit = 1'b1;
            way = w;
         end
      check_eq("idle_busy", bus.busy, 0);
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr;
      step();
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
      check_eq("acc_busy", bus.busy, 1);
      if (hit) begin
         check_eq("hit_rd_done", bus.rd_done, !is_wr);
         check_eq("hit_wr_done", bus.wr_done, is_wr);
         check_eq("hit_way",     bus.da_way,  way);
         check_eq("hit_set",     bus.da_set,  set);
         check_eq("hit_word",    bus.da_word, word);
         check_eq("hit_da_we",   bus.da_we,   is_wr);
         if (is_wr) check_eq("hit_src", bus.da_src_mem, 0);
         check_eq("hit_no_mem",  bus.mem_req, 0);
         m_hits++;
      end else begin
         vic = m_order[set][WAYS-1];
         for (int w = int'(WAYS) - 1; w >= 0; w--)
            if (!m_valid[set][w]) vic = w;
         wb = m_valid[set][vic] && m_dirty[set][vic];
         beats_exp = wb ? 2 * WORDS : WORDS;
         nbeats = 0;
         done = 1'b0;
         cyc = 0;
         check_eq("miss_no_done", bus.rd_done | bus.wr_done, 0);
         while (!done && cyc < 300) begin
            if (bus.rd_done || bus.wr_done) begin
               done = 1'b1;
               check_eq("miss_beats",   nbeats,      beats_exp);
               check_eq("miss_req_low", bus.mem_req, 0);
               check_eq("miss_rd_done", bus.rd_done, !is_wr);
               check_eq("miss_way",     bus.da_way,  vic);
               check_eq("miss_set",     bus.da_set,  set);
               check_eq("miss_word",    bus.da_word, word);
               check_eq("miss_da_we",   bus.da_we,   is_wr);
            end else if (bus.mem_req && $urandom_range(0, 2) != 0) begin
               in_wb = wb && nbeats < WORDS;
               b = nbeats % WORDS;
               exp_addr = (((in_wb ? m_tag[set][vic] : tag) * SETS + set) * WORDS + b) * 4;
               check_eq("beat_addr", bus.mem_addr, exp_addr);
               check_eq("beat_we",   bus.mem_we,   in_wb);
               check_eq("beat_word", bus.da_word,  b);
               check_eq("beat_way",  bus.da_way,   vic);
               bus.mem_ack = 1'b1;
               #1;
               check_eq("beat_da_we", bus.da_we, !in_wb);
               if (!in_wb) check_eq("beat_src", bus.da_src_mem, 1);
               nbeats++;
               step();
               bus.mem_ack = 1'b0;
            end else begin
               // requests while busy must be dropped
               if ($urandom_range(0, 3) == 0) begin
                  bus.cpu_rd = 1'b1;
                  bus.cpu_addr = $urandom;
               end
               step();
               bus.cpu_rd = 1'b0;
            end
            cyc++;
         end
         if (!done) check_eq("miss_timeout", 0, 1);
         m_tag[set][vic]   = tag;
         m_valid[set][vic] = 1'b1;
         m_dirty[set][vic] = 1'b0;
         way = vic;
         m_misses++;
      end
      touch(set, way);
      if (is_wr) m_dirty[set][way] = 1'b1;
      step();
      check_eq("post_busy",    bus.busy,    0);
      check_eq("post_rd_done", bus.rd_done, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned n, cyc, op;
      logic [31:0] a;
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.mem_ack = 1'b0;
      do_reset();

      do_access(32'h0000_1040, 1, 0);
      do_access(32'h0000_1040, 1, 0);
`ifdef CACHE_STATS_EN
      check_eq("stats_hit1",  hit_cnt,  1);
      check_eq("stats_miss1", miss_cnt, 1);
`endif
      do_access(32'h0000_1044, 0, 1);
      do_access(32'h0000_1140, 1, 0);
      do_access(32'h0000_1240, 1, 0);
      do_access(32'h0000_1340, 1, 0);
      do_access(32'h0000_1440, 1, 0);   // evicts dirty way 0

      do_reset();
      do_access(32'h0000_1040, 1, 0);
      do_access(32'h0000_1140, 1, 0);
      do_access(32'h0000_1240, 1, 0);
      do_access(32'h0000_1340, 1, 0);
      do_access(32'h0000_1040, 1, 0);
      do_access(32'h0000_1440, 1, 0);   // replaces way 1

      // reset during refill beat 3
      do_reset();
      bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h0000_1040;
      step();
      bus.cpu_rd = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 100) begin
         if (bus.mem_req) begin
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
            n++;
         end else step();
         cyc++;
      end
      check_eq("midrst_req_before", bus.mem_req, 1);
      reset = 1'b1;
      step();
      check_eq("midrst_req", bus.mem_req, 0);
      check_eq("midrst_busy", bus.busy, 0);
      reset = 1'b0;
      model_reset();
      do_access(32'h0000_1040, 1, 0);

      for (int i = 0; i < 400; i++) begin
         a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << OFF_W) |
             ($urandom_range(0, WORDS - 1) << 2) | $urandom_range(0, 3);
         op = $urandom_range(0, 2);
         do_access(a, op != 1, op != 0);
      end
`ifdef CACHE_STATS_EN
      check_eq("stats_hits",   hit_cnt,  m_hits);
      check_eq("stats_misses", miss_cnt, m_misses);
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      step();
      release dut.hit_cnt_q;
      do_access(32'h0000_1040, 1, 0);
      do_access(32'h0000_1040, 1, 0);
      check_eq("stats_sat", hit_cnt, 32'hFFFF_FFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_nway.md
Name: cache_ctrl_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller.
- Owns the tag, valid, dirty and LRU state and sequences hit, write-back and refill.
- Drives the external data array and the line-burst memory interface; sits between the CPU load/store port and main memory.
- Supersedes the fixed 8-set compare/refill controller; the defaults reproduce its address split (24-bit tag / 3-bit set / 5-bit offset).

Parameters:
- WAYS, 4: associativity; power of two, ≥2.
- SETS, 8: number of sets; power of two.
- WORDS, 8: 32-bit words per line; power of two.
- ADDR_W, 32: byte address width.
- Derived: OFF_W = log2(WORDS)+2; IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_rd  in  1  read request, sampled only when busy=0
- cpu_wr  in  1  write request, sampled only when busy=0
- cpu_addr  in  ADDR_W  byte address
- busy  out  1  controller is not accepting requests
- rd_done  out  1  one-cycle pulse: read data valid on the data array this cycle
- wr_done  out  1  one-cycle pulse: write committed
- da_way  out  log2(WAYS)  data array way select
- da_set  out  IDX_W  data array set select
- da_word  out  log2(WORDS)  data array word select
- da_we  out  1  data array write enable
- da_src_mem  out  1  write source: 1 = memory read data, 0 = CPU write data
- mem_req  out  1  memory beat request, held until mem_ack
- mem_we  out  1  1 = write-back beat, 0 = refill beat
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_ack  in  1  beat complete; ignored while mem_req=0

Behaviour:
- Address split: tag = addr[ADDR_W-1:IDX_W+OFF_W]; set = addr[IDX_W+OFF_W-1:OFF_W]; word = addr[OFF_W-1:2].
- Reset: all valid and dirty bits cleared; set ages = way index; state IDLE.
- Reset outputs: busy, rd_done, wr_done, da_we, mem_req, mem_we = 0; all buses 0.
- IDLE: on cpu_rd|cpu_wr, latch address and op, go to COMPARE, busy=1. If both are asserted, the request is treated as a write.
- COMPARE: tag-match all valid ways in the set.
  - Hit: rd_done or wr_done for one cycle. A write also sets dirty and pulses da_we with da_src_mem=0. Update LRU; return to IDLE; busy=0 next cycle.
  - Hit latency: response 1 cycle after the accepting edge.
- Miss: victim = lowest-index invalid way, else the way with age WAYS-1.
  - Victim dirty: go to WRITEBACK.
  - Victim clean: go to REFILL.
- WRITEBACK: WORDS beats with mem_we=1 and mem_addr={victim tag, set, beat, 2'b00}.
  - Beat counter starts at 0 and advances on mem_ack; da_word = counter.
  - On the last ack, clear dirty and go to REFILL.
- REFILL: WORDS beats with mem_we=0 and mem_addr={req tag, set, beat, 2'b00}.
  - On each ack: da_we=1, da_src_mem=1.
  - On the last ack: write tag, set valid, clear dirty, go to COMPARE. The re-compare is a guaranteed hit and completes the request.
- LRU ages (log2(WAYS) bits per way per set): the accessed way gets age 0; every way whose age is below its old age increments; the other ways are unchanged. Ages stay a permutation of 0..WAYS-1.
- mem_req drops the cycle after the final ack. Back-to-back beats are allowed: mem_req stays high and the counter advances each ack.
- Reset mid-burst: next cycle IDLE, mem_req=0, all lines invalid. No write-back of dirty data is performed.
- CPU requests during busy are ignored and not queued.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both saturating at 0xFFFF_FFFF and cleared by reset.
  - A hit increments on a first-pass COMPARE hit only; the post-refill re-compare does not count.
  - A miss increments on entry to WRITEBACK or REFILL.
- Undefined: the ports and counters are absent.

Decomposition:
- Package cache_pkg: state enum (IDLE, COMPARE, WRITEBACK, REFILL) and width helper functions for OFF_W, IDX_W and TAG_W.
- Sub-module cache_lru_ages: per-set age storage, update-on-access and victim index output, parametrised by WAYS and SETS.

Test Plan:
- Cold read of 0x0000_1040 (tag 0x10, set 2, word 0) → REFILL beats to mem_addr 0x1040..0x105C. After 8 acks, rd_done with da_way=0, and 8 mem_req beats total.
- Repeat read of 0x1040 → rd_done exactly 1 cycle after acceptance, no mem_req.
- Write 0x1044 (hit) then misses to tags 0x11..0x14 in set 2 → the fifth distinct tag evicts way 0. WRITEBACK beats go to 0x1040..0x105C with mem_we=1, then refill.
- LRU order: after accesses to tags 0x10, 0x11, 0x12, 0x13 in set 2 and a re-read of 0x10, a miss on tag 0x14 replaces way 1 (tag 0x11).
- reset asserted during refill beat 3 → next cycle mem_req=0 and busy=0. A read of 0x1040 then misses again.
- With CACHE_STATS_EN: scenarios 1–2 give hit_cnt=1 and miss_cnt=1. Forcing hit_cnt to 0xFFFF_FFFF then taking a hit leaves it at 0xFFFF_FFFF.
